id_ex_stage: RTL and testbench

ID/EX pipeline register of the five-stage pipeline CPU; it sits directly downstream of the register file. Each cycle it captures the two register-file read ports plus decoded fields for the EX stage. It corrects same-cycle writeback collisions with a WB bypass, detects load-use hazards, inserts bubbles, and honours downstream hold and flush.

---
 rtl/id_ex_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | id_ex_stage
// | ID/EX pipeline register with writeback bypass, load-use stall,
// | downstream hold (with operand refresh) and flush.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [31:0]       rdata_A,
  input  logic [31:0]       rdata_B,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_req,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              r_valid;
  logic              r_mem_read;
  logic              r_reg_write;
  logic [31:0]       r_pc;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [CTRL_W-1:0] r_ctrl;

  logic              w_wb_live;
  logic [31:0]       w_byp_a;
  logic [31:0]       w_byp_b;
  logic              w_hazard;

  // Register 0 is hard-wired in the file, so a write to it must never bypass.
  assign w_wb_live = wb_we && (wb_addr != 5'd0);
  assign w_byp_a   = (w_wb_live && (wb_addr == id_rs)) ? wb_data : rdata_A;
  assign w_byp_b   = (w_wb_live && (wb_addr == id_rt)) ? wb_data : rdata_B;

  assign w_hazard  = id_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                     ((r_rd == id_rs) || (r_rd == id_rt));
  assign stall_req = w_hazard && !flush && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
      r_pc        <= 32'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_imm       <= 32'd0;
      r_rs        <= 5'd0;
      r_rt        <= 5'd0;
      r_rd        <= 5'd0;
      r_ctrl      <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
      r_pc        <= 32'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_imm       <= 32'd0;
      r_rs        <= 5'd0;
      r_rt        <= 5'd0;
      r_rd        <= 5'd0;
      r_ctrl      <= '0;
    end else if (ex_stall) begin
      // Held operands would otherwise miss a writeback that retires meanwhile.
      if (w_wb_live && r_valid) begin
        if (wb_addr == r_rs) r_a <= wb_data;
        if (wb_addr == r_rt) r_b <= wb_data;
      end
    end else if (w_hazard) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_mem_read  <= id_valid && id_mem_read;
      r_reg_write <= id_valid && id_reg_write;
      r_pc        <= id_pc;
      r_a         <= w_byp_a;
      r_b         <= w_byp_b;
      r_imm       <= id_imm;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_rd        <= id_rd;
      r_ctrl      <= id_ctrl;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_mem_read  = r_mem_read;
  assign ex_reg_write = r_reg_write;
  assign ex_pc        = r_pc;
  assign ex_a         = r_a;
  assign ex_b         = r_b;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_ctrl      = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_id_ex_stage
// | Table-driven bench for id_ex_stage plus hold-refresh and async-reset runs.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic        id_mem_read, id_reg_write;
  logic [31:0] rdata_A, rdata_B;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        stall_req;
  logic        ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_ctrl;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .rdata_A(rdata_A), .rdata_B(rdata_B), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .stall_req(stall_req),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        mr, rw;
    logic [31:0] ra, rb;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stl, fl;
    logic        e_st;
    logic        e_v, e_mr, e_rw;
    logic        chk;
    logic [31:0] e_pc, e_a, e_b;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_imm;
    logic [7:0]  e_ctrl;
  } vec_t;

  vec_t tbl[16];

  task automatic cmp(input string nm, input logic [153:0] act, input logic [153:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v;   id_pc = t.pc;   id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    id_imm = t.imm;   id_ctrl = t.ctrl; id_mem_read = t.mr; id_reg_write = t.rw;
    rdata_A = t.ra;   rdata_B = t.rb;
    wb_we = t.we;     wb_addr = t.wa; wb_data = t.wd;
    ex_stall = t.stl; flush = t.fl;
  endtask

  function automatic logic [153:0] act_bus();
    return {ex_valid, ex_mem_read, ex_reg_write, ex_pc, ex_a, ex_b,
            ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl};
  endfunction

  task automatic check_out(input string nm, input vec_t t);
    logic [153:0] exp;
    logic [153:0] act;
    exp = {t.e_v, t.e_mr, t.e_rw, t.e_pc, t.e_a, t.e_b,
           t.e_rs, t.e_rt, t.e_rd, t.e_imm, t.e_ctrl};
    act = act_bus();
    if (!t.chk) begin
      // Only the qualifiers are defined after a load-use bubble.
      exp = {exp[153:151], 151'd0};
      act = {act[153:151], 151'd0};
    end
    cmp(nm, act, exp);
  endtask

  task automatic run_vec(input string nm, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    cmp({nm, " stall_req"}, {153'd0, stall_req}, {153'd0, t.e_st});
    @(posedge clk);
    #1;
    check_out({nm, " out"}, t);
  endtask

  vec_t idle, h;

  initial begin
    // Stimulus {ID/WB/control inputs} -> {stall_req before edge, EX outputs after edge}.
    tbl[0]  = '{1'b1,32'h40,5'd1,5'd2,5'd4,32'h10,8'h5A,1'b0,1'b1,32'h100,32'h200,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b1,1'b1,32'h40,32'h100,32'h200,5'd1,5'd2,5'd4,32'h10,8'h5A};
    tbl[1]  = '{1'b1,32'h44,5'd5,5'd6,5'd7,32'h20,8'h11,1'b0,1'b1,32'h11,32'h22,1'b1,5'd5,32'hAB,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b1,1'b1,32'h44,32'hAB,32'h22,5'd5,5'd6,5'd7,32'h20,8'h11};
    tbl[2]  = '{1'b1,32'h48,5'd8,5'd9,5'd10,32'h30,8'h22,1'b0,1'b1,32'h33,32'h44,1'b1,5'd9,32'hCD,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b1,1'b1,32'h48,32'h33,32'hCD,5'd8,5'd9,5'd10,32'h30,8'h22};
    tbl[3]  = '{1'b1,32'h4C,5'd0,5'd0,5'd0,32'h0,8'h00,1'b0,1'b0,32'h0,32'h0,1'b1,5'd0,32'hEE,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b0,1'b1,32'h4C,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00};
    tbl[4]  = '{1'b1,32'h50,5'd3,5'd3,5'd2,32'h4,8'h33,1'b0,1'b1,32'h55,32'h55,1'b0,5'd3,32'h77,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b1,1'b1,32'h50,32'h55,32'h55,5'd3,5'd3,5'd2,32'h4,8'h33};
    tbl[5]  = '{1'b0,32'h54,5'd1,5'd1,5'd1,32'h0,8'hFF,1'b1,1'b1,32'hAA,32'hBB,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b0,1'b0,1'b0,1'b1,32'h54,32'hAA,32'hBB,5'd1,5'd1,5'd1,32'h0,8'hFF};
    tbl[6]  = '{1'b1,32'h58,5'd1,5'd2,5'd3,32'h8,8'h44,1'b1,1'b1,32'h1000,32'h2000,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b1,1'b1,1'b1,1'b1,32'h58,32'h1000,32'h2000,5'd1,5'd2,5'd3,32'h8,8'h44};
    tbl[7]  = '{1'b1,32'h5C,5'd4,5'd3,5'd5,32'hC,8'h55,1'b0,1'b1,32'h60,32'h70,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00};
    tbl[8]  = '{1'b1,32'h5C,5'd4,5'd3,5'd5,32'hC,8'h55,1'b0,1'b1,32'h60,32'h70,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b1,1'b1,32'h5C,32'h60,32'h70,5'd4,5'd3,5'd5,32'hC,8'h55};
    tbl[9]  = '{1'b1,32'h60,5'd0,5'd0,5'd6,32'h0,8'h66,1'b1,1'b1,32'h0,32'h0,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b1,1'b1,1'b1,1'b1,32'h60,32'h0,32'h0,5'd0,5'd0,5'd6,32'h0,8'h66};
    tbl[10] = '{1'b1,32'h64,5'd6,5'd1,5'd2,32'h1,8'h77,1'b0,1'b1,32'h123,32'h456,1'b0,5'd0,32'h0,1'b1,1'b1,
                1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00};
    tbl[11] = '{1'b1,32'h68,5'd0,5'd0,5'd7,32'h0,8'h88,1'b1,1'b1,32'h0,32'h0,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b1,1'b1,1'b1,1'b1,32'h68,32'h0,32'h0,5'd0,5'd0,5'd7,32'h0,8'h88};
    tbl[12] = '{1'b1,32'h6C,5'd2,5'd7,5'd9,32'h2,8'h99,1'b0,1'b1,32'h300,32'h400,1'b1,5'd0,32'h5,1'b1,1'b0,
                1'b1,1'b1,1'b1,1'b1,1'b1,32'h68,32'h0,32'h0,5'd0,5'd0,5'd7,32'h0,8'h88};
    tbl[13] = '{1'b1,32'h6C,5'd2,5'd7,5'd9,32'h2,8'h99,1'b0,1'b1,32'h300,32'h400,1'b0,5'd0,32'h0,1'b1,1'b0,
                1'b1,1'b1,1'b1,1'b1,1'b1,32'h68,32'h0,32'h0,5'd0,5'd0,5'd7,32'h0,8'h88};
    tbl[14] = '{1'b1,32'h6C,5'd2,5'd7,5'd9,32'h2,8'h99,1'b0,1'b1,32'h300,32'h400,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00};
    tbl[15] = '{1'b1,32'h6C,5'd2,5'd7,5'd9,32'h2,8'h99,1'b0,1'b1,32'h300,32'h400,1'b0,5'd0,32'h0,1'b0,1'b0,
                1'b0,1'b1,1'b0,1'b1,1'b1,32'h6C,32'h300,32'h400,5'd2,5'd7,5'd9,32'h2,8'h99};

    idle = '{1'b0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00,1'b0,1'b0,32'h0,32'h0,1'b0,5'd0,32'h0,1'b0,1'b0,
             1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,8'h00};

    // Reset with random inputs.
    rst = 1'b1;
    h = idle;
    h.v = 1'b1; h.pc = $urandom; h.rs = 5'($urandom); h.rt = 5'($urandom); h.rd = 5'($urandom);
    h.mr = 1'b1; h.rw = 1'b1; h.ra = $urandom; h.rb = $urandom; h.we = 1'b1; h.wd = $urandom;
    h.wa = h.rs; h.stl = 1'($urandom); h.fl = 1'b0;
    drive(h);
    #1;
    cmp("reset out t0", act_bus(), 154'd0);
    cmp("reset stall_req t0", {153'd0, stall_req}, 154'd0);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset out after edges", act_bus(), 154'd0);
    cmp("reset stall_req after edges", {153'd0, stall_req}, 154'd0);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Hold refresh: ex_stall for three cycles, WB retires to ex_rs then ex_rt.
    h = '{1'b1,32'h80,5'd7,5'd8,5'd1,32'h3,8'h12,1'b0,1'b1,32'h1,32'h2,1'b0,5'd0,32'h0,1'b0,1'b0,
          1'b0,1'b1,1'b0,1'b1,1'b1,32'h80,32'h1,32'h2,5'd7,5'd8,5'd1,32'h3,8'h12};
    run_vec("hold load", h);
    h.pc = 32'h84; h.rs = 5'd9; h.rt = 5'd9; h.rd = 5'd9; h.ra = 32'hEE; h.rb = 32'hEE;
    h.imm = 32'h77; h.ctrl = 8'hEE; h.stl = 1'b1;
    run_vec("hold c1", h);
    h.we = 1'b1; h.wa = 5'd7; h.wd = 32'h99; h.e_a = 32'h99;
    run_vec("hold c2", h);
    h.wa = 5'd8; h.wd = 32'h42; h.e_b = 32'h42;
    run_vec("hold c3", h);

    // Async reset pulse between edges while held.
    @(negedge clk);
    h.we = 1'b0;
    drive(h);
    #2 rst = 1'b1;
    #1;
    cmp("async rst out", act_bus(), 154'd0);
    cmp("async rst stall_req", {153'd0, stall_req}, 154'd0);
    #1 rst = 1'b0;
    h = '{1'b1,32'hC0,5'd1,5'd2,5'd3,32'h5,8'h21,1'b0,1'b1,32'hA1,32'hB2,1'b0,5'd0,32'h0,1'b0,1'b0,
          1'b0,1'b1,1'b0,1'b1,1'b1,32'hC0,32'hA1,32'hB2,5'd1,5'd2,5'd3,32'h5,8'h21};
    drive(h);
    @(posedge clk);
    #1;
    check_out("post-reset load", h);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
